// File: rtl/axi_hp_burst_responder.sv
// AXI3-style memory responder shared by the ADC write DMA and DAC read DMA.
// One on-chip RAM, independent write and read burst engines on one clock.
module axi_hp_burst_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,
  // write address
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [3:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awcache,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  // write data
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  // write response
  output logic                    s_axi_bvalid,
  output logic [1:0]              s_axi_bresp,
  input  logic                    s_axi_bready,
  // read address
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [3:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arcache,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  // read data
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Only 8-byte beats with FIXED or INCR bursts are serviced normally.
  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'b011) || burst[1];
  endfunction

  // Protection/cache attributes and out-of-range address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awprot, s_axi_awcache, s_axi_arprot, s_axi_arcache,
                           s_axi_awaddr[ADDR_WIDTH-1:IDX_W+3], s_axi_awaddr[2:0],
                           s_axi_araddr[ADDR_WIDTH-1:IDX_W+3], s_axi_araddr[2:0]};

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // ---------------------------------------------------------------- write side
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  wstate_t          wstate_q;
  logic [IDX_W-1:0] widx_q;
  logic [IDX_W-1:0] widx_d;
  logic [3:0]       wcnt_q;
  logic             wfixed_q;
  logic             werr_q;
  logic             wmism_q;
  logic             awready_q;
  logic             wready_q;
  logic             bvalid_q;
  logic [1:0]       bresp_q;
  logic             w_hs;
  logic             wlast_bad;
  logic             mem_we;

  assign w_hs      = (wstate_q == W_DATA) && s_axi_wvalid && wready_q;
  assign wlast_bad = s_axi_wlast != (wcnt_q == 4'd0);
  assign mem_we    = w_hs && !werr_q;
  assign widx_d    = wfixed_q ? widx_q : widx_q + 1'b1;

  // Write burst engine: accept address, count beats, report response.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wstate_q  <= W_IDLE;
      widx_q    <= '0;
      wcnt_q    <= '0;
      wfixed_q  <= 1'b0;
      werr_q    <= 1'b0;
      wmism_q   <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (s_axi_awvalid && awready_q) begin
            widx_q    <= s_axi_awaddr[IDX_W+2:3];
            wcnt_q    <= s_axi_awlen;
            wfixed_q  <= (s_axi_awburst == 2'b00);
            werr_q    <= burst_err(s_axi_awsize, s_axi_awburst);
            wmism_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wstate_q  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            widx_q <= widx_d;
            wcnt_q <= wcnt_q - 4'd1;
            // The beat count, not wlast, decides where the burst ends.
            if (wcnt_q == 4'd0) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (werr_q || wmism_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
              wstate_q <= W_RESP;
            end else if (wlast_bad) begin
              wmism_q <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Byte-lane masked RAM write; no reset so it maps onto block RAM.
  always_ff @(posedge axi_aclk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (s_axi_wstrb[i]) begin
          mem[widx_q][8*i +: 8] <= s_axi_wdata[8*i +: 8];
        end
      end
    end
  end

  // ----------------------------------------------------------------- read side
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

  rstate_t               rstate_q;
  logic [IDX_W-1:0]      ridx_q;
  logic [IDX_W-1:0]      ridx_d;
  logic [3:0]            rcnt_q;
  logic                  rfixed_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic                  rlast_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  r_hs;
  logic                  rd_en;

  assign r_hs   = rvalid_q && s_axi_rready;
  // A new word is fetched only when the presented beat is consumed, so rdata
  // holds through stalls and the next beat is ready one cycle after a handshake.
  assign rd_en  = (rstate_q == R_FETCH) || ((rstate_q == R_DATA) && r_hs && !rlast_q);
  assign ridx_d = rfixed_q ? ridx_q : ridx_q + 1'b1;

  // Registered RAM read port; sampling before the write lands gives read-before-write.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= mem[ridx_q];
    end
  end

  // Read burst engine: accept address, prime the RAM read, stream beats.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      rstate_q  <= R_IDLE;
      ridx_q    <= '0;
      rcnt_q    <= '0;
      rfixed_q  <= 1'b0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (s_axi_arvalid && arready_q) begin
            ridx_q    <= s_axi_araddr[IDX_W+2:3];
            rcnt_q    <= s_axi_arlen;
            rfixed_q  <= (s_axi_arburst == 2'b00);
            rresp_q   <= burst_err(s_axi_arsize, s_axi_arburst) ? RESP_SLVERR : RESP_OKAY;
            arready_q <= 1'b0;
            rstate_q  <= R_FETCH;
          end
        end
        R_FETCH: begin
          ridx_q   <= ridx_d;
          rvalid_q <= 1'b1;
          rlast_q  <= (rcnt_q == 4'd0);
          rstate_q <= R_DATA;
        end
        R_DATA: begin
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              rstate_q  <= R_IDLE;
            end else begin
              ridx_q  <= ridx_d;
              rcnt_q  <= rcnt_q - 4'd1;
              rlast_q <= (rcnt_q == 4'd1);
            end
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;

endmodule
